dmem_responder: RTL and testbench

Memory-side responder for the data-cache bus, sitting behind the D-cache MSHR logic as the far end of its memory command/response protocol. It accepts one BUS_LOAD or BUS_STORE per cycle and acknowledges each with a combinational response tag. Loads return their data after a fixed latency on a tag-matched return bus; stores write a local 64-bit word store. It is a synthesizable memory model with finite tags and back-pressure, used to exercise MSHR allocation, retry and tag matching.

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_responder_if.sv | 38 +++
 rtl/dmem_responder_tag_pool.sv | 64 ++++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared definitions for the data-cache memory bus responder.
//               Holds the bus command encodings (common with the cache side),
//               the fixed store acknowledgement tag, the size of the load tag
//               pool, the in-flight load entry layout and a saturating
//               decrement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [3:0] STORE_ACK_TAG = 4'd15;
    localparam int         NUM_LOAD_TAGS = 14;

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] data;
        logic [4:0]  countdown;
    } inflight_entry_t;

    function automatic logic [4:0] sat_dec(input logic [4:0] value);
        return (value == 5'd0) ? 5'd0 : value - 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Data-cache memory command/response bus.
//   master : cache side - drives command, address, store data, mem_busy
//   slave  : memory side - drives response tag, return tag and return data
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic [1:0]  proc2Dmem_command;
    logic [63:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic        mem_busy;
    logic [3:0]  Dmem2proc_response;
    logic [3:0]  Dmem2proc_tag;
    logic [63:0] Dmem2proc_data;

    modport master (
        output proc2Dmem_command,
        output proc2Dmem_addr,
        output proc2Dmem_data,
        output mem_busy,
        input  Dmem2proc_response,
        input  Dmem2proc_tag,
        input  Dmem2proc_data
    );

    modport slave (
        input  proc2Dmem_command,
        input  proc2Dmem_addr,
        input  proc2Dmem_data,
        input  mem_busy,
        output Dmem2proc_response,
        output Dmem2proc_tag,
        output Dmem2proc_data
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder_tag_pool.sv
`default_nettype none
// ============================================================================
// Module      : dmem_tag_pool
// Description : Pool of load tags 1..NUM_LOAD_TAGS kept as a registered
//               free-bit vector. Offers the lowest-numbered free tag every
//               cycle and accepts one tag back per cycle.
//   clock, reset : system clock, synchronous active-high reset (all free)
//   i_alloc_en   : consume o_alloc_tag this cycle
//   o_alloc_tag  : lowest free tag, 0 when the pool is empty
//   o_has_free   : at least one tag is free
//   i_free_en    : return i_free_tag to the pool at the next edge
//   i_free_tag   : tag being returned
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_tag_pool
    import dmem_responder_pkg::*;
(
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       i_alloc_en,
    output logic [3:0]      o_alloc_tag,
    output logic            o_has_free,
    input  wire logic       i_free_en,
    input  wire logic [3:0] i_free_tag
);

    // Bit i represents tag i+1.
    logic [NUM_LOAD_TAGS-1:0] r_free;
    logic [NUM_LOAD_TAGS-1:0] w_alloc_mask;
    logic [NUM_LOAD_TAGS-1:0] w_free_mask;

    // Scanning downwards lets the lowest free tag win.
    always_comb begin
        o_alloc_tag = 4'd0;
        for (int i = NUM_LOAD_TAGS - 1; i >= 0; i--) begin
            if (r_free[i]) begin
                o_alloc_tag = 4'(i + 1);
            end
        end
    end

    always_comb begin
        w_alloc_mask = '0;
        w_free_mask  = '0;
        for (int i = 0; i < NUM_LOAD_TAGS; i++) begin
            w_alloc_mask[i] = i_alloc_en && (o_alloc_tag == 4'(i + 1));
            w_free_mask[i]  = i_free_en  && (i_free_tag  == 4'(i + 1));
        end
    end

    assign o_has_free = |r_free;

    // Allocation reads only the registered vector, so a tag returned this
    // cycle is not offered again until the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_free <= '1;
        end else begin
            r_free <= (r_free & ~w_alloc_mask) | w_free_mask;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the data-cache bus. Accepts one
//               load or store per cycle, acknowledges it combinationally with
//               a tag, returns load data after MEM_LATENCY cycles on a
//               registered tag/data bus, and writes stores into a local
//               64-bit word store.
//   MEM_LATENCY : load acceptance to data return, 1..31 cycles
//   MEM_WORDS   : word store depth, power of two
//   clock, reset: system clock, synchronous active-high reset
//   bus         : dmem_responder_if slave port (command/addr/data/mem_busy
//                 in; response, return tag and return data out)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_LATENCY = 16,
    parameter int MEM_WORDS   = 1024
) (
    input  wire logic         clock,
    input  wire logic         reset,
    dmem_responder_if.slave   bus
);

    localparam int         c_IDX_W          = $clog2(MEM_WORDS);
    localparam logic [4:0] c_LOAD_COUNTDOWN = 5'(MEM_LATENCY - 1);
    localparam logic [3:0] c_LAST_SLOT      = 4'(NUM_LOAD_TAGS - 1);
    localparam logic       c_BYPASS         = (MEM_LATENCY == 1);

    logic [63:0]         r_mem [MEM_WORDS];
    inflight_entry_t     r_queue [NUM_LOAD_TAGS];
    logic [3:0]          r_head;
    logic [3:0]          r_tail;
    logic [3:0]          r_count;
    logic [3:0]          r_ret_tag;
    logic [63:0]         r_ret_data;

    logic [c_IDX_W-1:0]  w_idx;
    logic [63:0]         w_rd_data;
    logic                w_load_accept;
    logic                w_store_accept;
    logic [3:0]          w_alloc_tag;
    logic                w_has_free;
    logic                w_push;
    logic                w_pop;
    logic                w_bypass;
    inflight_entry_t     w_head;
    logic                w_unused_addr;

    assign w_idx         = bus.proc2Dmem_addr[3 +: c_IDX_W];
    assign w_unused_addr = ^{bus.proc2Dmem_addr[63:3+c_IDX_W], bus.proc2Dmem_addr[2:0]};
    assign w_rd_data     = r_mem[w_idx];

    // Reset masks acceptance so nothing is allocated or written during reset.
    assign w_load_accept  = !reset && (bus.proc2Dmem_command == BUS_LOAD)
                            && !bus.mem_busy && w_has_free;
    assign w_store_accept = !reset && (bus.proc2Dmem_command == BUS_STORE);

    always_comb begin
        bus.Dmem2proc_response = 4'd0;
        if (w_load_accept) begin
            bus.Dmem2proc_response = w_alloc_tag;
        end else if (w_store_accept) begin
            bus.Dmem2proc_response = STORE_ACK_TAG;
        end
    end

    // The tag on the return bus goes back to the pool at the end of its
    // return cycle, making it allocatable from the following cycle.
    dmem_tag_pool u_tag_pool (
        .clock       (clock),
        .reset       (reset),
        .i_alloc_en  (w_load_accept),
        .o_alloc_tag (w_alloc_tag),
        .o_has_free  (w_has_free),
        .i_free_en   (r_ret_tag != 4'd0),
        .i_free_tag  (r_ret_tag)
    );

    // Store write. The load read above is combinational on the pre-write
    // contents, so in-flight snapshots never see later stores.
    always_ff @(posedge clock) begin
        if (w_store_accept) begin
            r_mem[w_idx] <= bus.proc2Dmem_data;
        end
    end

    // With a one-cycle latency the accepted load goes straight to the
    // return register and never enters the queue.
    assign w_bypass = c_BYPASS && w_load_accept;
    assign w_push   = w_load_accept && !c_BYPASS;
    assign w_head   = r_queue[r_head];
    // Pop is decided on the post-decrement countdown so the return register
    // is loaded at the edge that starts cycle accept+MEM_LATENCY.
    assign w_pop    = (r_count != 4'd0) && (sat_dec(w_head.countdown) == 5'd0);

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_LOAD_TAGS; i++) begin
            r_queue[i].countdown <= sat_dec(r_queue[i].countdown);
        end
        if (w_push) begin
            r_queue[r_tail] <= '{tag: w_alloc_tag, data: w_rd_data, countdown: c_LOAD_COUNTDOWN};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= 4'd0;
            r_tail  <= 4'd0;
            r_count <= 4'd0;
        end else begin
            if (w_push) begin
                r_tail <= (r_tail == c_LAST_SLOT) ? 4'd0 : r_tail + 4'd1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_LAST_SLOT) ? 4'd0 : r_head + 4'd1;
            end
            r_count <= r_count + 4'(w_push) - 4'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ret_tag  <= 4'd0;
            r_ret_data <= 64'd0;
        end else if (w_bypass) begin
            r_ret_tag  <= w_alloc_tag;
            r_ret_data <= w_rd_data;
        end else if (w_pop) begin
            r_ret_tag  <= w_head.tag;
            r_ret_data <= w_head.data;
        end else begin
            r_ret_tag  <= 4'd0;
            r_ret_data <= 64'd0;
        end
    end

    assign bus.Dmem2proc_tag  = r_ret_tag;
    assign bus.Dmem2proc_data = r_ret_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A reference model of
//               the tag pool and word store predicts every response; expected
//               returns are queued on acceptance and compared by a monitor in
//               the cycle they are due (all other cycles must show 0/0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int         L        = 16;
    localparam int         WORDS    = 1024;
    localparam logic [1:0] C_NONE   = 2'd0;
    localparam logic [1:0] C_LOAD   = 2'd1;
    localparam logic [1:0] C_STORE  = 2'd2;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } ret_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    bit   mon_en;

    logic [63:0] model_mem [WORDS];
    logic [14:1] model_free;
    logic [3:0]  pend_free;
    ret_t        sb[$];

    dmem_responder_if bus ();

    dmem_responder #(.MEM_LATENCY(L), .MEM_WORDS(WORDS)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (pend_free != 4'd0) begin
            model_free[pend_free] = 1'b1;
            pend_free = 4'd0;
        end
    end

    // Return-bus scoreboard: compares every cycle at the falling edge.
    always @(negedge clk) begin
        logic [3:0]  exp_tag;
        logic [63:0] exp_data;
        if (mon_en) begin
            exp_tag  = 4'd0;
            exp_data = 64'd0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_tag   = sb[0].tag;
                exp_data  = sb[0].data;
                pend_free = sb[0].tag;
                void'(sb.pop_front());
            end
            checks++;
            if (bus.Dmem2proc_tag !== exp_tag || bus.Dmem2proc_data !== exp_data) begin
                failures++;
                $display("FAIL return cyc=%0d got tag=%0d data=%h expected tag=%0d data=%h",
                         cyc, bus.Dmem2proc_tag, bus.Dmem2proc_data, exp_tag, exp_data);
            end
        end
    end

    // Drives one cycle, returns the DUT response and the model's prediction,
    // and advances the model. Entered and left at posedge+1.
    task automatic do_cycle(input logic r, input logic [1:0] cmd, input logic [63:0] addr,
                            input logic [63:0] data, input logic busy,
                            output logic [3:0] act, output logic [3:0] exp);
        int idx;
        rst                   = r;
        bus.proc2Dmem_command = cmd;
        bus.proc2Dmem_addr    = addr;
        bus.proc2Dmem_data    = data;
        bus.mem_busy          = busy;
        @(negedge clk);
        #1;
        act = bus.Dmem2proc_response;
        exp = 4'd0;
        idx = int'(addr[12:3]);
        if (r) begin
            sb.delete();
            model_free = '1;
            pend_free  = 4'd0;
        end else if (cmd == C_LOAD && !busy && model_free != '0) begin
            for (int t = 14; t >= 1; t--) begin
                if (model_free[t]) exp = 4'(t);
            end
            model_free[exp] = 1'b0;
            sb.push_back('{due: cyc + L, tag: exp, data: model_mem[idx]});
        end else if (cmd == C_STORE) begin
            exp = 4'd15;
            model_mem[idx] = data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic [3:0] a, e;
        int n;
        n = 0;
        while (sb.size() > 0 && n < 64) begin
            do_cycle(1'b0, C_NONE, 64'd0, 64'd0, 1'b0, a, e);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        do_cycle(1'b0, C_NONE, 64'd0, 64'd0, 1'b0, a, e);
    endtask

    task automatic test_reset();
        logic [3:0] a, e;
        checks++;
        if (bus.Dmem2proc_tag !== 4'd0 || bus.Dmem2proc_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs got tag=%0d data=%h expected 0/0",
                     bus.Dmem2proc_tag, bus.Dmem2proc_data);
        end
        do_cycle(1'b1, C_LOAD, 64'h40, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd0) begin
            failures++;
            $display("FAIL reset_load_resp got %0d expected 0", a);
        end
        do_cycle(1'b1, C_STORE, 64'h100, 64'h1234, 1'b0, a, e);
        checks++;
        if (a !== 4'd0) begin
            failures++;
            $display("FAIL reset_store_resp got %0d expected 0", a);
        end
        // Must return the preloaded word, not 0x1234.
        do_cycle(1'b0, C_LOAD, 64'h100, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd1) begin
            failures++;
            $display("FAIL reset_first_tag got %0d expected 1", a);
        end
        drain();
    endtask

    task automatic test_store_load();
        logic [3:0] a, e;
        do_cycle(1'b0, C_STORE, 64'h40, 64'hDEAD_BEEF, 1'b0, a, e);
        checks++;
        if (a !== 4'd15) begin
            failures++;
            $display("FAIL store_ack got %0d expected 15", a);
        end
        do_cycle(1'b0, C_LOAD, 64'h40, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd1 || sb[0].data !== 64'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_load_resp got %0d expected 1", a);
        end
        drain();
    endtask

    task automatic test_snapshot();
        logic [3:0] a, e;
        do_cycle(1'b0, C_LOAD, 64'h80, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL snap_load0 got %0d expected %0d", a, e);
        end
        do_cycle(1'b0, C_STORE, 64'h80, 64'h5, 1'b0, a, e);
        do_cycle(1'b0, C_LOAD, 64'h80, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd2) begin
            failures++;
            $display("FAIL snap_load2 got %0d expected 2", a);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, e;
        int         n;
        for (int i = 0; i < 14; i++) begin
            do_cycle(1'b0, C_LOAD, 64'(i * 8), 64'd0, 1'b0, a, e);
            checks++;
            if (a !== 4'(i + 1)) begin
                failures++;
                $display("FAIL b2b_tag i=%0d got %0d expected %0d", i, a, i + 1);
            end
        end
        n = 14;
        a = 4'd0;
        while (a == 4'd0 && n < 40) begin
            do_cycle(1'b0, C_LOAD, 64'h3F8, 64'd0, 1'b0, a, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL b2b_retry cyc=%0d got %0d expected %0d", n, a, e);
            end
            n++;
        end
        checks++;
        if (n - 1 != 17 || a !== 4'd1) begin
            failures++;
            $display("FAIL b2b_15th accepted at %0d tag %0d expected 17 tag 1", n - 1, a);
        end
        drain();
    endtask

    task automatic test_busy();
        logic [3:0] a, e;
        do_cycle(1'b0, C_LOAD, 64'h200, 64'd0, 1'b1, a, e);
        checks++;
        if (a !== 4'd0) begin
            failures++;
            $display("FAIL busy_load0 got %0d expected 0", a);
        end
        do_cycle(1'b0, C_STORE, 64'h200, 64'hCAFE_F00D, 1'b1, a, e);
        checks++;
        if (a !== 4'd15) begin
            failures++;
            $display("FAIL busy_store got %0d expected 15", a);
        end
        do_cycle(1'b0, C_LOAD, 64'h200, 64'd0, 1'b1, a, e);
        checks++;
        if (a !== 4'd0) begin
            failures++;
            $display("FAIL busy_load2 got %0d expected 0", a);
        end
        do_cycle(1'b0, C_LOAD, 64'h200, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd1 || sb[0].data !== 64'hCAFE_F00D) begin
            failures++;
            $display("FAIL busy_load3 got %0d expected 1", a);
        end
        drain();
    endtask

    task automatic test_reset_drop();
        logic [3:0] a, e;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, C_LOAD, 64'(i * 8 + 8), 64'd0, 1'b0, a, e);
        end
        do_cycle(1'b0, C_NONE, 64'd0, 64'd0, 1'b0, a, e);
        do_cycle(1'b1, C_NONE, 64'd0, 64'd0, 1'b0, a, e);
        // Monitor now requires the return bus to stay idle.
        repeat (24) do_cycle(1'b0, C_NONE, 64'd0, 64'd0, 1'b0, a, e);
        do_cycle(1'b0, C_LOAD, 64'h18, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd1) begin
            failures++;
            $display("FAIL drop_first_tag got %0d expected 1", a);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [3:0] a, e;
        do_cycle(1'b0, C_STORE, 64'h2008, 64'h0123_4567_89AB_CDEF, 1'b0, a, e);
        do_cycle(1'b0, C_LOAD, 64'h0008, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd1 || sb[0].data !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL wrap_load got %0d expected 1", a);
        end
        do_cycle(1'b0, C_LOAD, 64'hFFFF_0000_0000_000F, 64'd0, 1'b0, a, e);
        checks++;
        if (a !== 4'd2) begin
            failures++;
            $display("FAIL wrap_alias got %0d expected 2", a);
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0]  a, e;
        logic [63:0] addr;
        for (int i = 0; i < 300; i++) begin
            addr = {($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0,
                    23'd0, 6'($urandom_range(0, 63)), 3'($urandom)};
            do_cycle(1'b0, 2'($urandom_range(0, 3)), addr, {32'($urandom), 32'($urandom)},
                     ($urandom_range(0, 3) == 0), a, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL random_resp cyc=%0d got %0d expected %0d", cyc, a, e);
            end
        end
        drain();
    endtask

    initial begin
        logic [63:0] v;
        cyc        = 0;
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        pend_free  = 4'd0;
        model_free = '1;
        for (int i = 0; i < WORDS; i++) begin
            v = {32'hA5A5_0000 | 32'(i), ~32'(i)};
            dut.r_mem[i] = v;
            model_mem[i] = v;
        end
        rst                   = 1'b1;
        bus.proc2Dmem_command = C_NONE;
        bus.proc2Dmem_addr    = 64'd0;
        bus.proc2Dmem_data    = 64'd0;
        bus.mem_busy          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        test_reset();
        test_store_load();
        test_snapshot();
        test_back_to_back();
        test_busy();
        test_reset_drop();
        test_wrap();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
